timer_bank: RTL

//   Multi-channel programmable interval timer; successor to the single counter.

---
 rtl/timer_bank.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/timer_bank.sv
// timer_bank: multi-channel programmable interval timer.
//
// CHANNELS independent counters share one tick strobe. Each channel has its own
// runtime-written period, periodic/one-shot mode, start/stop control and a
// registered one-cycle terminal-count pulse.
//
// Optional feature macro: TIMER_PRESCALER_EN
//   defined   : an internal prescaler divides tick by PRESCALE; channels advance only
//               on the tick where the prescaler wraps to 0.
//   undefined : tick drives the channels directly; PRESCALE is ignored.
//
// Ports
//   clk           clock
//   rst           synchronous, active-high reset
//   i_tick        global count strobe
//   i_cfg_we      config write strobe
//   i_cfg_ch      channel addressed by the config write
//   i_cfg_period  new period (0 = free-running, never terminal)
//   i_cfg_oneshot 1 = one-shot, 0 = periodic
//   i_start       per-channel start pulse
//   i_stop        per-channel stop pulse (beats start)
//   o_count       packed counts, channel i at [i*WIDTH +: WIDTH]
//   o_tc          registered terminal-count pulse, one cycle
//   o_running     channel is in RUN
//   o_done        sticky: one-shot channel has expired
module timer_bank #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              i_tick,
  input  logic                                              i_cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] i_cfg_ch,
  input  logic [WIDTH-1:0]                                  i_cfg_period,
  input  logic                                              i_cfg_oneshot,
  input  logic [CHANNELS-1:0]                               i_start,
  input  logic [CHANNELS-1:0]                               i_stop,
  output logic [CHANNELS*WIDTH-1:0]                         o_count,
  output logic [CHANNELS-1:0]                               o_tc,
  output logic [CHANNELS-1:0]                               o_running,
  output logic [CHANNELS-1:0]                               o_done
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Channel advance strobe, after optional prescaling.
  logic w_adv;

`ifdef TIMER_PRESCALER_EN
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0] r_pre;
  logic             w_pre_wrap;

  assign w_pre_wrap = (r_pre == PRE_W'(PRESCALE - 1));
  assign w_adv      = i_tick & w_pre_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (i_tick) begin
      r_pre <= w_pre_wrap ? '0 : r_pre + PRE_W'(1);
    end
  end
`else
  logic w_prescale_unused;
  assign w_prescale_unused = (PRESCALE != 0);
  assign w_adv             = i_tick;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_e           r_state, w_state;
    logic [WIDTH-1:0] r_count, w_count;
    logic [WIDTH-1:0] r_period, w_period;
    logic             r_oneshot, w_oneshot;
    logic             r_tc, w_tc;
    logic             w_sel;
    logic             w_term;

    assign w_sel  = i_cfg_we && (i_cfg_ch == CH_W'(c));
    // Period 0 never terminates; the counter simply wraps at 2^WIDTH.
    assign w_term = (r_period != '0) && (r_count >= r_period - WIDTH'(1));

    // Priority: config write, then stop, then start, then normal counting.
    // Any of the first three suppresses a coincident terminal tick.
    always_comb begin
      w_state   = r_state;
      w_count   = r_count;
      w_period  = r_period;
      w_oneshot = r_oneshot;
      w_tc      = 1'b0;
      if (w_sel) begin
        w_period  = i_cfg_period;
        w_oneshot = i_cfg_oneshot;
        w_count   = '0;
        w_state   = (i_start[c] && !i_stop[c]) ? StRun : StIdle;
      end else if (i_stop[c]) begin
        w_state = StIdle;
      end else if (i_start[c]) begin
        w_state = StRun;
        w_count = '0;
      end else begin
        case (r_state)
          StRun: begin
            if (w_adv) begin
              if (w_term) begin
                w_count = '0;
                w_tc    = 1'b1;
                if (r_oneshot) begin
                  w_state = StDone;
                end
              end else begin
                w_count = r_count + WIDTH'(1);
              end
            end
          end
          StDone:  w_count = '0;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state   <= StIdle;
        r_count   <= '0;
        r_period  <= '0;
        r_oneshot <= 1'b0;
        r_tc      <= 1'b0;
      end else begin
        r_state   <= w_state;
        r_count   <= w_count;
        r_period  <= w_period;
        r_oneshot <= w_oneshot;
        r_tc      <= w_tc;
      end
    end

    assign o_count[c*WIDTH +: WIDTH] = r_count;
    assign o_tc[c]                   = r_tc;
    assign o_running[c]              = (r_state == StRun);
    assign o_done[c]                 = (r_state == StDone);
  end

endmodule
